// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control sequencer for the MIPS datapath.
// Latches op/func in FETCH, decodes them into the datapath control bus and
// steps each instruction through FETCH/DECODE/EXEC/MEM/WB. Write strobes and
// the PC load are registered one-cycle pulses.
module mc_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [5:0]       op,
    input  logic [5:0]       func,
    output logic             RegDst,
    output logic             ALUSrc,
    output logic             MemtoReg,
    output logic             RegWr,
    output logic             MemWr,
    output logic             ExtOp,
    output logic [3:0]       ALUctr,
    output logic [3:0]       NPCop,
    output logic             PCWr,
    output logic [2:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    // Instruction classes that determine the path through the FSM
    localparam logic [2:0] CLS_ALU = 3'd0;
    localparam logic [2:0] CLS_LW  = 3'd1;
    localparam logic [2:0] CLS_SW  = 3'd2;
    localparam logic [2:0] CLS_BR  = 3'd3;
    localparam logic [2:0] CLS_ILL = 3'd4;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_SLT = 4'd4;
    localparam logic [3:0] ALU_SLL = 4'd5;
    localparam logic [3:0] ALU_SRL = 4'd6;
    localparam logic [3:0] ALU_LUI = 4'd7;

    localparam logic [3:0] NPC_SEQ = 4'd0;
    localparam logic [3:0] NPC_BEQ = 4'd1;
    localparam logic [3:0] NPC_BNE = 4'd2;
    localparam logic [3:0] NPC_J   = 4'd3;

    state_t           r_state;
    logic [5:0]       r_op_q;
    logic [5:0]       r_func_q;
    logic             r_regwr;
    logic             r_memwr;
    logic             r_pcwr;
    logic             r_illegal;
    logic [CNT_W-1:0] r_retired;

    logic             w_regdst;
    logic             w_alusrc;
    logic             w_memtoreg;
    logic             w_extop;
    logic [3:0]       w_aluctr;
    logic [3:0]       w_npcop;
    logic [2:0]       w_cls;
    logic             w_active;

    // Decode the latched instruction into control fields and a class
    always_comb begin
        w_regdst   = 1'b0;
        w_alusrc   = 1'b0;
        w_memtoreg = 1'b0;
        w_extop    = 1'b0;
        w_aluctr   = ALU_ADD;
        w_npcop    = NPC_SEQ;
        w_cls      = CLS_ILL;
        case (r_op_q)
            6'h00: begin
                w_regdst = 1'b1;
                w_cls    = CLS_ALU;
                case (r_func_q)
                    6'h21:   w_aluctr = ALU_ADD;
                    6'h23:   w_aluctr = ALU_SUB;
                    6'h24:   w_aluctr = ALU_AND;
                    6'h25:   w_aluctr = ALU_OR;
                    6'h2A:   w_aluctr = ALU_SLT;
                    6'h00:   w_aluctr = ALU_SLL;
                    6'h02:   w_aluctr = ALU_SRL;
                    default: begin
                        w_regdst = 1'b0;
                        w_cls    = CLS_ILL;
                    end
                endcase
            end
            6'h0D: begin
                w_cls    = CLS_ALU;
                w_aluctr = ALU_OR;
                w_alusrc = 1'b1;
            end
            6'h09: begin
                w_cls    = CLS_ALU;
                w_aluctr = ALU_ADD;
                w_alusrc = 1'b1;
                w_extop  = 1'b1;
            end
            6'h0F: begin
                w_cls    = CLS_ALU;
                w_aluctr = ALU_LUI;
                w_alusrc = 1'b1;
            end
            6'h23: begin
                w_cls      = CLS_LW;
                w_alusrc   = 1'b1;
                w_extop    = 1'b1;
                w_memtoreg = 1'b1;
            end
            6'h2B: begin
                w_cls    = CLS_SW;
                w_alusrc = 1'b1;
                w_extop  = 1'b1;
            end
            6'h04: begin
                w_cls    = CLS_BR;
                w_aluctr = ALU_SUB;
                w_extop  = 1'b1;
                w_npcop  = NPC_BEQ;
            end
            6'h05: begin
                w_cls    = CLS_BR;
                w_aluctr = ALU_SUB;
                w_extop  = 1'b1;
                w_npcop  = NPC_BNE;
            end
            6'h02: begin
                w_cls   = CLS_BR;
                w_npcop = NPC_J;
            end
            default: w_cls = CLS_ILL;
        endcase
    end

    // Sequencer: state, instruction latch, one-cycle strobes and counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_FETCH;
            r_op_q    <= 6'd0;
            r_func_q  <= 6'd0;
            r_regwr   <= 1'b0;
            r_memwr   <= 1'b0;
            r_pcwr    <= 1'b0;
            r_illegal <= 1'b0;
            r_retired <= {CNT_W{1'b0}};
        end else begin
            r_regwr <= 1'b0;
            r_memwr <= 1'b0;
            r_pcwr  <= 1'b0;
            // The PC-load cycle retires the instruction unless it was illegal
            if (r_pcwr && (w_cls != CLS_ILL)) begin
                r_retired <= r_retired + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_retired <= r_retired;
            end
            case (r_state)
                ST_FETCH: begin
                    if (run) begin
                        r_op_q   <= op;
                        r_func_q <= func;
                        r_state  <= ST_DECODE;
                    end else begin
                        r_state  <= ST_FETCH;
                    end
                end
                ST_DECODE: begin
                    r_state <= ST_EXEC;
                    // Flag and PC-load become visible during EXEC itself
                    if (w_cls == CLS_ILL) begin
                        r_illegal <= 1'b1;
                    end else begin
                        r_illegal <= r_illegal;
                    end
                    if ((w_cls == CLS_BR) || (w_cls == CLS_ILL)) begin
                        r_pcwr <= 1'b1;
                    end else begin
                        r_pcwr <= 1'b0;
                    end
                end
                ST_EXEC: begin
                    case (w_cls)
                        CLS_ALU: begin
                            r_state <= ST_WB;
                            r_regwr <= 1'b1;
                            r_pcwr  <= 1'b1;
                        end
                        CLS_LW:  r_state <= ST_MEM;
                        CLS_SW: begin
                            r_state <= ST_MEM;
                            r_memwr <= 1'b1;
                            r_pcwr  <= 1'b1;
                        end
                        default: r_state <= ST_FETCH;
                    endcase
                end
                ST_MEM: begin
                    if (w_cls == CLS_LW) begin
                        r_state <= ST_WB;
                        r_regwr <= 1'b1;
                        r_pcwr  <= 1'b1;
                    end else begin
                        r_state <= ST_FETCH;
                    end
                end
                ST_WB:   r_state <= ST_FETCH;
                default: r_state <= ST_FETCH;
            endcase
        end
    end

    // Static controls are blanked in FETCH, where op_q still holds the
    // previous instruction.
    assign w_active = (r_state != ST_FETCH);
    assign RegDst   = w_active & w_regdst;
    assign ALUSrc   = w_active & w_alusrc;
    assign MemtoReg = w_active & w_memtoreg;
    assign ExtOp    = w_active & w_extop;
    assign ALUctr   = w_active ? w_aluctr : 4'd0;
    assign NPCop    = r_pcwr ? w_npcop : NPC_SEQ;
    assign RegWr    = r_regwr;
    assign MemWr    = r_memwr;
    assign PCWr     = r_pcwr;
    assign state    = r_state;
    assign illegal  = r_illegal;
    assign retired  = r_retired;

endmodule
